// File: rtl/cache.sv
// Direct-mapped 256-line data cache storage with per-line MESI state.
// Stores and returns line contents only; hit/miss and coherence decisions
// belong to the CPU. Reads are registered (1-cycle latency), read-before-write.

package definesPkg;
   typedef enum logic [1:0] {
      INV = 2'd0,
      SHD = 2'd1,
      EXC = 2'd2,
      MOD = 2'd3
   } Tmesi_state;

   typedef struct packed {
      logic [23:0] Page_reference;
      logic [7:0]  Index;
   } Taddress;
endpackage

module cache
   import definesPkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  mesi_state_in,
   output logic [31:0] rdata,
   output logic [1:0]  cache_mesi_state,
   output logic [31:0] cache_addr
);

   Taddress    w_addr;
   logic [7:0] w_index;

   logic [31:0] r_data  [256];
   logic [23:0] r_tag   [256];
   Tmesi_state  r_state [256];

   logic [31:0] r_rdata;
   Tmesi_state  r_mesi;
   logic [31:0] r_cache_addr;

   assign w_addr  = addr;
   assign w_index = w_addr.Index;

   // Line storage: cleared to INV/zero on reset, written on we.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 256; i++) begin
            r_data[i[7:0]]  <= '0;
            r_tag[i[7:0]]   <= '0;
            r_state[i[7:0]] <= INV;
         end
      end else if (we) begin
         r_data[w_index]  <= wdata;
         r_tag[w_index]   <= w_addr.Page_reference;
         r_state[w_index] <= Tmesi_state'(mesi_state_in);
      end
   end

   // Registered read of the selected line; sees pre-write contents on a write edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdata      <= '0;
         r_mesi       <= INV;
         r_cache_addr <= '0;
      end else begin
         r_rdata      <= r_data[w_index];
         r_mesi       <= r_state[w_index];
         r_cache_addr <= {r_tag[w_index], w_index};
      end
   end

   assign rdata            = r_rdata;
   assign cache_mesi_state = r_mesi;
   assign cache_addr       = r_cache_addr;

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: directed scenarios plus randomized traffic
// checked against an array-based model of line contents.

module tb_cache;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  mesi_state_in;
   logic [31:0] rdata;
   logic [1:0]  cache_mesi_state;
   logic [31:0] cache_addr;

   int n_checks = 0;
   int n_fail   = 0;

   // Model of the line contents
   logic [31:0] m_data  [256];
   logic [23:0] m_tag   [256];
   logic [1:0]  m_state [256];

   logic [65:0] obs;
   assign obs = {rdata, cache_addr, cache_mesi_state};

   cache dut (
      .clk              (clk),
      .reset            (reset),
      .we               (we),
      .addr             (addr),
      .wdata            (wdata),
      .mesi_state_in    (mesi_state_in),
      .rdata            (rdata),
      .cache_mesi_state (cache_mesi_state),
      .cache_addr       (cache_addr)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) begin
         m_data[i]  = '0;
         m_tag[i]   = '0;
         m_state[i] = 2'd0;
      end
   endtask

   function automatic logic [65:0] exp_line(input logic [7:0] idx);
      return {m_data[idx], m_tag[idx], idx, m_state[idx]};
   endfunction

   task automatic do_write(input logic [7:0] idx, input logic [23:0] tag,
                           input logic [31:0] d, input logic [1:0] st);
      we = 1'b1;
      addr = {tag, idx};
      wdata = d;
      mesi_state_in = st;
      cyc();
      we = 1'b0;
      m_data[idx]  = d;
      m_tag[idx]   = tag;
      m_state[idx] = st;
   endtask

   // Present an index for reading with an arbitrary (ignored) page tag.
   task automatic present(input logic [7:0] idx);
      logic [23:0] junk;
      junk = 24'($urandom());
      we = 1'b0;
      addr = {junk, idx};
      wdata = $urandom();
      mesi_state_in = 2'($urandom());
      cyc();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      #2;
      @(negedge clk);
      reset = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      logic [7:0] idx_list [3];
      idx_list[0] = 8'd0;
      idx_list[1] = 8'd127;
      idx_list[2] = 8'd255;
      do_write(8'd0,   24'h111111, 32'hCAFE0000, 2'd3);
      do_write(8'd127, 24'h222222, 32'hCAFE0127, 2'd2);
      do_write(8'd255, 24'h333333, 32'hCAFE0255, 2'd1);
      present(8'd127);
      // Start a write to line 0x10 and assert reset before its edge
      we = 1'b1;
      addr = {24'h123456, 8'h10};
      wdata = 32'h87654321;
      mesi_state_in = 2'd3;
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (obs !== 66'h0) begin
         n_fail++;
         $display("FAIL reset_immediate: got %h expected %h", obs, 66'h0);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (obs !== 66'h0) begin
         n_fail++;
         $display("FAIL reset_held: got %h expected %h", obs, 66'h0);
      end
      we = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      for (int k = 0; k < 3; k++) begin
         present(idx_list[k]);
         n_checks++;
         if (obs !== {32'h0, 24'h0, idx_list[k], 2'd0}) begin
            n_fail++;
            $display("FAIL reset_line_%0d: got %h expected %h", idx_list[k], obs,
                     {32'h0, 24'h0, idx_list[k], 2'd0});
         end
      end
      present(8'h10);
      n_checks++;
      if (obs !== {32'h0, 32'h00000010, 2'd0}) begin
         n_fail++;
         $display("FAIL reset_discard_write: got %h expected %h", obs,
                  {32'h0, 32'h00000010, 2'd0});
      end
   endtask

   task automatic test_write_read();
      do_write(8'h3C, 24'hABCDEF, 32'hDEADBEEF, 2'd1);
      present(8'h3C);
      n_checks++;
      if (obs !== {32'hDEADBEEF, 32'hABCDEF3C, 2'd1}) begin
         n_fail++;
         $display("FAIL write_read: got %h expected %h", obs,
                  {32'hDEADBEEF, 32'hABCDEF3C, 2'd1});
      end
   endtask

   task automatic test_read_before_write();
      do_write(8'd5, 24'h000055, 32'h11111111, 2'd2);
      we = 1'b1;
      addr = {24'h000066, 8'd5};
      wdata = 32'h22222222;
      mesi_state_in = 2'd3;
      cyc();
      we = 1'b0;
      n_checks++;
      if (obs !== {32'h11111111, 24'h000055, 8'd5, 2'd2}) begin
         n_fail++;
         $display("FAIL rbw_old: got %h expected %h", obs,
                  {32'h11111111, 24'h000055, 8'd5, 2'd2});
      end
      m_data[5] = 32'h22222222;
      m_tag[5]  = 24'h000066;
      m_state[5] = 2'd3;
      cyc();
      n_checks++;
      if (obs !== {32'h22222222, 24'h000066, 8'd5, 2'd3}) begin
         n_fail++;
         $display("FAIL rbw_new: got %h expected %h", obs,
                  {32'h22222222, 24'h000066, 8'd5, 2'd3});
      end
   endtask

   task automatic test_back_to_back();
      do_write(8'd1, 24'hB0B001, 32'd1, 2'd1);
      do_write(8'd2, 24'hB0B002, 32'd2, 2'd2);
      do_write(8'd3, 24'hB0B003, 32'd3, 2'd3);
      for (int k = 1; k <= 3; k++) begin
         present(8'(k));
         n_checks++;
         if (obs !== {32'(k), 24'hB0B000 + 24'(k), 8'(k), 2'(k)}) begin
            n_fail++;
            $display("FAIL back_to_back_%0d: got %h expected %h", k, obs,
                     {32'(k), 24'hB0B000 + 24'(k), 8'(k), 2'(k)});
         end
      end
   endtask

   task automatic test_boundary();
      do_write(8'd255, 24'h000001, 32'h0000FFFF, 2'd2);
      present(8'd255);
      n_checks++;
      if (obs !== {32'h0000FFFF, 32'h000001FF, 2'd2}) begin
         n_fail++;
         $display("FAIL boundary_255: got %h expected %h", obs,
                  {32'h0000FFFF, 32'h000001FF, 2'd2});
      end
      present(8'd0);
      n_checks++;
      if (obs !== exp_line(8'd0)) begin
         n_fail++;
         $display("FAIL boundary_line0: got %h expected %h", obs, exp_line(8'd0));
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic [7:0] idx;
         case ($urandom_range(0, 9))
            0:       idx = 8'd0;
            1:       idx = 8'd255;
            default: idx = 8'($urandom_range(0, 15) * 16 + $urandom_range(0, 3));
         endcase
         if ($urandom_range(0, 1) == 1) begin
            do_write(idx, 24'($urandom()), $urandom(), 2'($urandom()));
         end else begin
            present(idx);
            n_checks++;
            if (obs !== exp_line(idx)) begin
               n_fail++;
               $display("FAIL random_read_%0d: got %h expected %h", idx, obs, exp_line(idx));
            end
         end
      end
   endtask

   task automatic test_sweep();
      pulse_reset();
      do_write(8'd0,   24'h0A0A0A, 32'hA5A5A5A5, 2'd1);
      do_write(8'd254, 24'h0FEFEF, 32'h5A5A5A5A, 2'd1);
      for (int i = 0; i <= 254; i++) begin
         we = 1'b0;
         addr = {24'($urandom()), 8'(i)};
         if (i > 0) begin
            n_checks++;
            if (obs !== exp_line(8'(i - 1))) begin
               n_fail++;
               $display("FAIL sweep_line_%0d: got %h expected %h", i - 1, obs,
                        exp_line(8'(i - 1)));
            end
         end
         cyc();
      end
      n_checks++;
      if (obs !== {32'h5A5A5A5A, 24'h0FEFEF, 8'd254, 2'd1}) begin
         n_fail++;
         $display("FAIL sweep_line_254: got %h expected %h", obs,
                  {32'h5A5A5A5A, 24'h0FEFEF, 8'd254, 2'd1});
      end
   endtask

   initial begin
      reset = 1'b0;
      we = 1'b0;
      addr = '0;
      wdata = '0;
      mesi_state_in = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== 66'h0) begin
         n_fail++;
         $display("FAIL power_on_reset: got %h expected %h", obs, 66'h0);
      end
      @(negedge clk);
      reset = 1'b1;
      test_reset();
      test_write_read();
      test_read_before_write();
      test_back_to_back();
      test_boundary();
      test_random();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
